// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server: one Fibonacci LFSR shared by NUM_REQ requesters under round-robin arbitration,
// with seed loading and a post-seed warm-up phase before any word is issued.
module lfsr_rr_server #(
   parameter int               NUM_REQ = 4,
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
   parameter logic [WIDTH-1:0] SEED    = 8'hE1,
   parameter int               WARMUP  = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [WIDTH-1:0]   rnd_o,
   input  logic               seed_load_i,
   input  logic [WIDTH-1:0]   seed_i,
   output logic               busy_o
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   typedef enum logic {WARM, RUN} state_t;
   localparam state_t INIT_STATE = (WARMUP == 0) ? RUN : WARM;

   state_t             r_state;
   logic [WIDTH-1:0]   r_lfsr, r_rnd, w_step;
   logic [NUM_REQ-1:0] r_gnt, w_elig, w_onehot;
   logic [PW-1:0]      r_ptr, w_win, w_ptr_nxt;
   logic [CW-1:0]      r_cnt;
   logic               w_found;

   assign w_step    = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
   assign w_elig    = req_i & ~r_gnt;
   assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
   assign w_ptr_nxt = (w_win == PW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

   // Lowest eligible index overall is the wrap-around fallback; lowest at/after r_ptr overrides it.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (w_elig[i]) begin
            w_found = 1'b1;
            w_win   = PW'(i);
         end
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (w_elig[i] && PW'(i) >= r_ptr) w_win = PW'(i);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= INIT_STATE;
         r_lfsr  <= SEED;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_rnd   <= '0;
      end else if (seed_load_i) begin
         r_lfsr  <= (seed_i == '0) ? SEED : seed_i;
         r_cnt   <= '0;
         r_state <= INIT_STATE;
         r_gnt   <= '0;
      end else if (r_state == WARM) begin
         r_lfsr  <= w_step;
         r_gnt   <= '0;
         r_cnt   <= (r_cnt == CW'(WARMUP-1)) ? '0 : r_cnt + 1'b1;
         r_state <= (r_cnt == CW'(WARMUP-1)) ? RUN : WARM;
      end else if (w_found) begin
         r_gnt   <= w_onehot;
         r_rnd   <= r_lfsr;
         r_lfsr  <= w_step;
         r_ptr   <= w_ptr_nxt;
      end else begin
         r_gnt   <= '0;
      end
   end

   assign gnt_o  = r_gnt;
   assign rnd_o  = r_rnd;
   assign busy_o = (r_state == WARM);

   a_invariants : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(r_gnt) && r_lfsr != '0);
endmodule

// File: tb/tb_lfsr_rr_server.sv
// tb_lfsr_rr_server: scenario tasks against a behavioural model of the shared-LFSR
// round-robin server (integer pointer, warm-up countdown, arithmetic LFSR step).
module tb_lfsr_rr_server;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req_i = '0;
   logic [3:0] gnt_o;
   logic [7:0] rnd_o;
   logic       seed_load_i = 1'b0;
   logic [7:0] seed_i = '0;
   logic       busy_o;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_lfsr, m_rnd;
   logic [3:0] m_gnt;
   int         m_ptr, m_warm;

   lfsr_rr_server dut (
      .clk(clk), .reset_n(reset_n), .req_i(req_i), .gnt_o(gnt_o), .rnd_o(rnd_o),
      .seed_load_i(seed_load_i), .seed_i(seed_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], 1'(($countones(x & 8'hB8)) % 2)};
   endfunction

   task automatic model_reset();
      m_lfsr = 8'hE1; m_rnd = 8'h00; m_gnt = 4'b0000; m_ptr = 0; m_warm = 4;
   endtask

   // Advance one clock edge, updating the model from the inputs present at that edge.
   task automatic tick();
      logic [3:0] elig;
      int win;
      @(posedge clk);
      if (seed_load_i) begin
         m_lfsr = (seed_i == 8'h00) ? 8'hE1 : seed_i;
         m_warm = 4;
         m_gnt  = 4'b0000;
      end else if (m_warm > 0) begin
         m_lfsr = lfsr_next(m_lfsr);
         m_warm--;
         m_gnt = 4'b0000;
      end else begin
         elig = req_i & ~m_gnt;
         win = -1;
         for (int k = 0; k < 4; k++)
            if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
         if (win < 0) m_gnt = 4'b0000;
         else begin
            m_gnt  = 4'(1 << win);
            m_rnd  = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            m_ptr  = (win + 1) % 4;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic exp_busy;
      reset_n = 1'b0; req_i = '0; seed_load_i = 1'b0;
      #13;
      checks++;
      if (gnt_o !== 4'b0000 || rnd_o !== 8'h00 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_values: gnt=%b rnd=%h busy=%b, required gnt=0000 rnd=00 busy=1", gnt_o, rnd_o, busy_o);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_busy = (i < 3);
         checks++;
         if (busy_o !== exp_busy || gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL warmup_edge%0d: busy=%b gnt=%b, required busy=%b gnt=0000", i+1, busy_o, gnt_o, exp_busy);
         end
      end
   endtask

   task automatic test_all_req();
      logic [7:0] exp_rnd [5] = '{8'h17, 8'h2F, 8'h5E, 8'hBC, 8'h78};
      req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt_o !== 4'(1 << (i % 4)) || rnd_o !== exp_rnd[i]) begin
            errors++;
            $display("FAIL all_req_grant%0d: gnt=%b rnd=%h, required gnt=%b rnd=%h", i, gnt_o, rnd_o, 4'(1 << (i % 4)), exp_rnd[i]);
         end
      end
   endtask

   task automatic test_single_req();
      int n = 0;
      req_i = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (gnt_o == 4'b0100) n++;
         checks++;
         if (gnt_o !== m_gnt || rnd_o !== m_rnd) begin
            errors++;
            $display("FAIL single_req_cycle%0d: gnt=%b rnd=%h, required gnt=%b rnd=%h", i, gnt_o, rnd_o, m_gnt, m_rnd);
         end
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL single_req_rate: grants=%0d, required 4 in 8 cycles", n);
      end
   endtask

   task automatic test_seed_zero();
      req_i = 4'b1111; seed_i = 8'h00; seed_load_i = 1'b1;
      tick();
      seed_load_i = 1'b0;
      checks++;
      if (gnt_o !== 4'b0000 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL seed_load_edge: gnt=%b busy=%b, required gnt=0000 busy=1", gnt_o, busy_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (busy_o !== (i < 3) || gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL seed_warm%0d: busy=%b gnt=%b, required busy=%b gnt=0000", i, busy_o, gnt_o, (i < 3));
         end
      end
      tick();
      checks++;
      if (gnt_o !== m_gnt || rnd_o !== 8'h17 || m_gnt !== 4'b1000) begin
         errors++;
         $display("FAIL seed_resume: gnt=%b rnd=%h, required gnt=1000 rnd=17", gnt_o, rnd_o);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_g [4] = '{4'b1000, 4'b0001, 4'b0000, 4'b0010};
      logic [3:0] stim  [4] = '{4'b1001, 4'b1001, 4'b0000, 4'b0011};
      req_i = 4'b0000; tick();
      req_i = 4'b0100; tick();
      req_i = 4'b0000; tick();
      for (int i = 0; i < 4; i++) begin
         req_i = stim[i];
         tick();
         checks++;
         if (gnt_o !== exp_g[i] || rnd_o !== m_rnd) begin
            errors++;
            $display("FAIL wrap_step%0d: gnt=%b rnd=%h, required gnt=%b rnd=%h", i, gnt_o, rnd_o, exp_g[i], m_rnd);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         req_i       = 4'($urandom);
         seed_load_i = ($urandom_range(0, 19) == 0);
         seed_i      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tick();
         checks++;
         if (gnt_o !== m_gnt || rnd_o !== m_rnd || busy_o !== (m_warm > 0)) begin
            errors++;
            $display("FAIL random_cycle%0d: gnt=%b rnd=%h busy=%b, required gnt=%b rnd=%h busy=%b",
                     i, gnt_o, rnd_o, busy_o, m_gnt, m_rnd, (m_warm > 0));
         end
      end
      seed_load_i = 1'b0;
   endtask

   task automatic test_async_reset();
      req_i = 4'b1111;
      for (int i = 0; i < 3; i++) tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (gnt_o !== 4'b0000 || rnd_o !== 8'h00 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: gnt=%b rnd=%h busy=%b, required gnt=0000 rnd=00 busy=1", gnt_o, rnd_o, busy_o);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (busy_o !== 1'b0 || gnt_o !== 4'b0000) begin
         errors++;
         $display("FAIL async_rewarm: busy=%b gnt=%b, required busy=0 gnt=0000", busy_o, gnt_o);
      end
      tick();
      checks++;
      if (gnt_o !== 4'b0001 || rnd_o !== 8'h17) begin
         errors++;
         $display("FAIL async_first_grant: gnt=%b rnd=%h, required gnt=0001 rnd=17", gnt_o, rnd_o);
      end
   endtask

   initial begin
      test_reset();
      test_all_req();
      test_single_req();
      test_seed_zero();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
